// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - sequential multiply/divide unit (shift-add multiply, restoring divide)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any in-flight operation
//   in_valid   request present           in_ready   unit idle, can accept
//   op         000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   a, b       operands (multiplicand/dividend, multiplier/divisor)
//   out_valid  result present            out_ready  consumer takes result
//   result     XLEN-bit result           zero       result == 0
module seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mc_q, mc_d;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // product low half (multiplier) / quotient (dividend)
  logic [XLEN-1:0]   res_q, res_d;

  // Operand decode at accept time
  logic            is_div, signed_a, signed_b, sa, sb, accept;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div   = op[2];
  assign signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign sa       = signed_a & a[XLEN-1];
  assign sb       = signed_b & b[XLEN-1];
  assign a_mag    = sa ? -a : a;
  assign b_mag    = sb ? -b : b;
  assign accept   = in_valid & in_ready;
  assign div_zero = is_div & (b == '0);
  // Only signed DIV/REM (op[0]==0) can overflow: most-negative / -1
  assign div_ovf  = is_div & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);

  // One shift-add step: add multiplicand when multiplier LSB is set, shift right
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(XLEN+1){1'b0}});

  // One restoring-divide step: shift next dividend bit in, subtract if it fits
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, mc_q};
  assign div_diff  = div_shift[XLEN-1:0] - mc_q;

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    mc_d    = mc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          cnt_d = '0;
          if (div_zero) begin
            res_d   = op[1] ? a : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = op[1] ? '0 : a;
            state_d = DONE;
          end else begin
            // REM takes the dividend's sign; everything else the sign product
            neg_d   = (is_div & op[1]) ? sa : (sa ^ sb);
            hi_d    = '0;
            lo_d    = is_div ? a_mag : b_mag;
            mc_d    = is_div ? b_mag : a_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mc_q    <= mc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = (res_q == '0);

endmodule
